// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction-memory port arbiter:
// arbiter state encoding, data word width and a word-index helper.
package imem_arb_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Word index of a byte address for a memory of 2**depth_log2 words.
    // The two byte-offset bits are dropped and the index wraps at the
    // memory size.
    function automatic logic [WORD_W-1:0] word_index(
        input logic [WORD_W-1:0] addr,
        input int unsigned       depth_log2
    );
        logic [WORD_W-1:0] mask_v;
        mask_v = (32'd1 << depth_log2) - 32'd1;
        return (addr >> 2) & mask_v;
    endfunction

endpackage

// File: rtl/imem_arb_rsp_reg.sv
// Per-port read response register: captures memory read data on a granted
// read and raises a one-cycle valid pulse; data is held until the next
// response of the same port.
module imem_arb_rsp_reg
    import imem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] rdata_in,
    output logic              rvalid,
    output logic [WORD_W-1:0] rdata
);

    // Latch read data and pulse valid one cycle after a granted read
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid <= 1'b0;
            rdata  <= {WORD_W{1'b0}};
        end else begin
            rvalid <= load;
            if (load) begin
                rdata <= rdata_in;
            end else begin
                rdata <= rdata;
            end
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbiter sharing one instruction-memory port between CPU fetch (F) and the
// program loader/debug port (L). One grant per cycle; F has priority until
// a pending L request has lost MAX_WAIT times. L may lock the port for
// burst loads. Read data is registered per port.
// Optional build macro: IMEM_ARB_STATS_EN adds grant/conflict counters.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [WORD_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [WORD_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [WORD_W-1:0] l_addr,
    input  logic [WORD_W-1:0] l_wdata,
    input  logic              l_lock,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [WORD_W-1:0] l_rdata,
    output logic [WORD_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [WORD_W-1:0] f_grant_cnt,
    output logic [WORD_W-1:0] l_grant_cnt,
    output logic [WORD_W-1:0] conflict_cnt
`endif
);

    // The address is forwarded whole; the memory itself wraps on the word
    // index, so DEPTH_LOG2 only describes the attached memory.
    localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    arb_state_e       state_r;
    arb_state_e       state_nxt_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_nxt_s;
    logic             arb_open_s;
    logic             f_gnt_s;
    logic             l_gnt_s;

    // State and starvation counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            wait_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Arbitration, lock tracking and starvation counter update
    always_comb begin
        arb_open_s     = 1'b1;
        f_gnt_s        = 1'b0;
        l_gnt_s        = 1'b0;
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;

        // A locked port reopens in the very cycle the loader drops l_lock
        case (state_r)
            IDLE:    arb_open_s = 1'b1;
            LOCKED:  arb_open_s = !l_lock;
            default: arb_open_s = 1'b1;
        endcase

        if (arb_open_s) begin
            if (f_req && (!l_req || (wait_cnt_r < MAX_WAIT_C))) begin
                f_gnt_s = 1'b1;
            end else begin
                l_gnt_s = l_req;
            end
            if (l_gnt_s && l_lock) begin
                state_nxt_s = LOCKED;
            end else begin
                state_nxt_s = IDLE;
            end
        end else begin
            l_gnt_s     = l_req;
            state_nxt_s = LOCKED;
        end

        if (!l_req || l_gnt_s) begin
            wait_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (f_gnt_s && (wait_cnt_r < MAX_WAIT_C)) begin
            wait_cnt_nxt_s = wait_cnt_r + CNT_ONE;
        end else begin
            wait_cnt_nxt_s = wait_cnt_r;
        end
    end

    // Memory-side mux: granted port drives address/strobe, idle drives zero
    always_comb begin
        mem_addr  = {WORD_W{1'b0}};
        mem_we    = 1'b0;
        mem_wdata = {WORD_W{1'b0}};
        if (f_gnt_s) begin
            mem_addr = f_addr;
        end else if (l_gnt_s) begin
            mem_addr = l_addr;
            mem_we   = l_we;
            if (l_we) begin
                mem_wdata = l_wdata;
            end else begin
                mem_wdata = {WORD_W{1'b0}};
            end
        end else begin
            mem_addr = {WORD_W{1'b0}};
        end
    end

    assign f_gnt = f_gnt_s;
    assign l_gnt = l_gnt_s;

    imem_arb_rsp_reg u_f_rsp (
        .clk      (clk),
        .reset    (reset),
        .load     (f_gnt_s),
        .rdata_in (mem_rdata),
        .rvalid   (f_rvalid),
        .rdata    (f_rdata)
    );

    imem_arb_rsp_reg u_l_rsp (
        .clk      (clk),
        .reset    (reset),
        .load     (l_gnt_s & ~l_we),
        .rdata_in (mem_rdata),
        .rvalid   (l_rvalid),
        .rdata    (l_rdata)
    );

`ifdef IMEM_ARB_STATS_EN
    // Free-running grant and conflict counters, wrapping at 2**32
    always_ff @(posedge clk) begin
        if (reset) begin
            f_grant_cnt  <= {WORD_W{1'b0}};
            l_grant_cnt  <= {WORD_W{1'b0}};
            conflict_cnt <= {WORD_W{1'b0}};
        end else begin
            f_grant_cnt  <= f_grant_cnt  + {{(WORD_W-1){1'b0}}, f_gnt_s};
            l_grant_cnt  <= l_grant_cnt  + {{(WORD_W-1){1'b0}}, l_gnt_s};
            conflict_cnt <= conflict_cnt + {{(WORD_W-1){1'b0}}, (f_req & l_req)};
        end
    end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: table-driven vectors, directed
// lock/reset/wrap sequences and random traffic against a behavioural model.
// Build with IMEM_ARB_STATS_EN defined to also check the counters.
module tb_imem_port_arbiter;

    localparam int DEPTH_LOG2 = 6;
    localparam int MAX_WAIT   = 4;
    localparam int NWORDS     = 1 << DEPTH_LOG2;

    logic        clk;
    logic        reset;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        l_req;
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_lock;
    logic        l_gnt;
    logic        l_rvalid;
    logic [31:0] l_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef IMEM_ARB_STATS_EN
    logic [31:0] f_grant_cnt;
    logic [31:0] l_grant_cnt;
    logic [31:0] conflict_cnt;
`endif

    imem_port_arbiter #(.DEPTH_LOG2(DEPTH_LOG2), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .l_req     (l_req),
        .l_we      (l_we),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_lock    (l_lock),
        .l_gnt     (l_gnt),
        .l_rvalid  (l_rvalid),
        .l_rdata   (l_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef IMEM_ARB_STATS_EN
        ,
        .f_grant_cnt  (f_grant_cnt),
        .l_grant_cnt  (l_grant_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    // Clock: 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached memory: combinational read, write on the rising edge, wraps
    logic [31:0] mem [NWORDS];
    assign mem_rdata = mem[mem_addr[DEPTH_LOG2+1:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[DEPTH_LOG2+1:2]] <= mem_wdata;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] ref_mem [NWORDS];
    bit          locked;
    int          waits;
    bit          known;
    logic        exp_frv, exp_lrv;
    logic [31:0] exp_frd, exp_lrd;
    int unsigned cnt_f, cnt_l, cnt_c;
    logic        obs_fg, obs_lg, obs_we;
    bit          last_eg_f, last_eg_l;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % NWORDS);
    endfunction

    // One clock cycle: drive at the falling edge, check the combinational
    // outputs, advance the model, check registered outputs at the next falling edge.
    task automatic cycle(input logic rs, input logic fr, input logic [31:0] fa,
                         input logic lr, input logic lw, input logic [31:0] la,
                         input logic [31:0] ld, input logic ll);
        bit eg_f, eg_l;
        logic [31:0] ea;
        reset = rs; f_req = fr; f_addr = fa; l_req = lr; l_we = lw;
        l_addr = la; l_wdata = ld; l_lock = ll;
        #1;
        eg_f = 1'b0;
        eg_l = 1'b0;
        if (locked && ll) eg_l = lr;
        else if (fr && (!lr || waits < MAX_WAIT)) eg_f = 1'b1;
        else eg_l = lr;
        ea = eg_f ? fa : (eg_l ? la : 32'd0);
        obs_fg = f_gnt;
        obs_lg = l_gnt;
        obs_we = mem_we;
        if (known) begin
            chk("f_gnt", {31'd0, f_gnt}, {31'd0, eg_f});
            chk("l_gnt", {31'd0, l_gnt}, {31'd0, eg_l});
            chk("mem_addr", mem_addr, ea);
            chk("mem_we", {31'd0, mem_we}, {31'd0, (eg_l && lw)});
            if (eg_l && lw) chk("mem_wdata", mem_wdata, ld);
        end
        last_eg_f = eg_f;
        last_eg_l = eg_l;
        if (rs) begin
            locked = 0; waits = 0;
            exp_frv = 1'b0; exp_lrv = 1'b0; exp_frd = 32'd0; exp_lrd = 32'd0;
            cnt_f = 0; cnt_l = 0; cnt_c = 0;
        end else begin
            exp_frv = eg_f;
            if (eg_f) exp_frd = ref_mem[widx(fa)];
            exp_lrv = eg_l && !lw;
            if (eg_l && !lw) exp_lrd = ref_mem[widx(la)];
            if (eg_l && lw) ref_mem[widx(la)] = ld;
            if (!(locked && ll)) locked = eg_l && ll;
            if (!lr || eg_l) waits = 0;
            else if (eg_f) waits = (waits + 1 > MAX_WAIT) ? MAX_WAIT : waits + 1;
            if (eg_f) cnt_f++;
            if (eg_l) cnt_l++;
            if (fr && lr) cnt_c++;
        end
        @(negedge clk);
        if (rs) known = 1;
        chk("f_rvalid", {31'd0, f_rvalid}, {31'd0, exp_frv});
        chk("f_rdata", f_rdata, exp_frd);
        chk("l_rvalid", {31'd0, l_rvalid}, {31'd0, exp_lrv});
        chk("l_rdata", l_rdata, exp_lrd);
    endtask

    typedef struct {
        logic        fr;
        logic [31:0] fa;
        logic        lr;
        logic [31:0] la;
        logic        xfg;
        logic        xlg;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // fetch-only back-to-back reads of words 0,1,2
        tbl[0] = '{1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 32'h4, 1'b0, 32'h0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 32'h8, 1'b0, 32'h0, 1'b1, 1'b0};
        // continuous contention: F four times, then L once, repeating
        for (int i = 0; i < 10; i++) begin
            tbl[3 + i] = '{1'b1, 32'h10, 1'b1, 32'h20,
                           ((i % 5) != 4), ((i % 5) == 4)};
        end

        for (int i = 0; i < NWORDS; i++) begin
            mem[i] = i;
            ref_mem[i] = i;
        end
        locked = 0; waits = 0; known = 0;
        exp_frv = 1'b0; exp_lrv = 1'b0; exp_frd = 32'd0; exp_lrd = 32'd0;
        cnt_f = 0; cnt_l = 0; cnt_c = 0;
        reset = 1'b1; f_req = 1'b0; f_addr = 32'd0; l_req = 1'b0; l_we = 1'b0;
        l_addr = 32'd0; l_wdata = 32'd0; l_lock = 1'b0;

        @(negedge clk);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("reset_f_rvalid", {31'd0, f_rvalid}, 32'd0);
        chk("reset_l_rdata", l_rdata, 32'd0);

        // Table-driven vectors
        for (int i = 0; i < 13; i++) begin
            cycle(1'b0, tbl[i].fr, tbl[i].fa, tbl[i].lr, 1'b0, tbl[i].la, 32'd0, 1'b0);
            chk($sformatf("tbl%0d_f_gnt", i), {31'd0, obs_fg}, {31'd0, tbl[i].xfg});
            chk($sformatf("tbl%0d_l_gnt", i), {31'd0, obs_lg}, {31'd0, tbl[i].xlg});
            if (i < 3) chk($sformatf("tbl%0d_f_rdata", i), f_rdata, i);
        end

        // Locked burst of four writes while F keeps requesting
        begin
            int n;
            n = 0;
            do begin
                cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1);
                n++;
            end while (!last_eg_l && n < 8);
            chk("lock_first_gnt", {31'd0, obs_lg}, 32'd1);
            for (int k = 1; k < 4; k++) begin
                cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 32'h40 + 4 * k, 32'hDEADBEEF + k, 1'b1);
                chk("lock_f_blocked", {31'd0, obs_fg}, 32'd0);
                chk("lock_l_gnt", {31'd0, obs_lg}, 32'd1);
            end
            cycle(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            chk("unlock_f_gnt", {31'd0, obs_fg}, 32'd1);
            chk("unlock_f_rdata", f_rdata, 32'hDEADBEEF);
        end

        // Plain loader write: strobe only in the grant cycle, no read response
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'hCAFEF00D, 1'b0);
        chk("wr_mem_we", {31'd0, obs_we}, 32'd1);
        chk("wr_no_l_rvalid", {31'd0, l_rvalid}, 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("idle_mem_we", {31'd0, obs_we}, 32'd0);

        // Reset while locked with a read in flight
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1);
        chk("rst_l_rvalid_pre", {31'd0, l_rvalid}, 32'd1);
        cycle(1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h48, 32'h0, 1'b1);
        chk("rst_l_rvalid_dropped", {31'd0, l_rvalid}, 32'd0);
        cycle(1'b0, 1'b1, 32'h4C, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("rst_f_gnt_after", {31'd0, obs_fg}, 32'd1);
        chk("rst_f_rdata_after", f_rdata, 32'hDEADBEEF + 32'd3);

        // Address wrap with ignored byte-offset bits
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h12345678, 1'b0);
        cycle(1'b0, 1'b1, 32'h103, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("wrap_f_rdata", f_rdata, 32'h12345678);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle((($urandom % 64) == 0), (($urandom % 4) != 0), $urandom,
                  (($urandom % 2) == 0), (($urandom % 2) == 0), $urandom,
                  $urandom, (($urandom % 3) == 0));
        end

`ifdef IMEM_ARB_STATS_EN
        chk("f_grant_cnt", f_grant_cnt, cnt_f);
        chk("l_grant_cnt", l_grant_cnt, cnt_l);
        chk("conflict_cnt", conflict_cnt, cnt_c);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
